dmem_ctrl: RTL
==============

Name: dmem_ctrl

Overview:
- Parametrised word-addressed data memory with a valid/ready request port, a fixed-latency read response, per-byte write enables and out-of-range detection.
- Adds a post-reset clear sequencer so contents are deterministic without a preload file.
- Sits between the CPU memory stage and the data RAM array; it is the next generation of the team's data memory.

Parameters:
- DATA_W, 32, data word width; must be a multiple of 8.
- ADDR_W, 32, request address width.
- DEPTH, 1024, number of words; addresses 0..DEPTH-1 are valid.
- READ_LAT, 1, cycles from read accept to rsp_valid; legal values 1 or 2.
- CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = skip clearing.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables; bit i covers bits [8i+7:8i].
- rsp_valid  out  1  read response valid, one-cycle pulse.
- rsp_rdata  out  DATA_W  read data; 0 whenever rsp_valid=0.
- rsp_err  out  1  qualified by rsp_valid; out-of-range read (or parity fault).
- clr_busy  out  1  clear sequence in progress.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, clr_busy=0, read pipeline cleared, FSM=CLEAR (CLEAR_ON_RESET=1) or READY (CLEAR_ON_RESET=0). Array contents are not reset.
- FSM state CLEAR:
  - clr_busy=1, req_ready=0.
  - A clear counter of width $clog2(DEPTH) starts at 0 and writes word 0 at counter, one word per cycle.
  - After writing DEPTH-1 the FSM goes to READY, so CLEAR lasts exactly DEPTH cycles.
- FSM state READY: req_ready=1, clr_busy=0. No exit except reset.
- Reset asserted mid-CLEAR: the sequence restarts at 0 after reset release. Reset mid-read: the pending response is discarded and no rsp_valid is produced.
- A request is accepted when req_valid & req_ready are both 1 on a clock edge.
- Writes:
  - Enabled bytes of word req_addr are updated on the accept edge; disabled bytes are unchanged.
  - req_be=0 is a legal no-op.
  - No response is produced.
- Reads:
  - rsp_valid pulses exactly READ_LAT cycles after the accept edge, carrying the word and rsp_err=0.
  - Back-to-back reads give one response per cycle, in order.
- Ordering: a write accepted at edge N is visible to a read accepted at edge N+1 or later. There is no same-edge conflict because only one request is accepted per cycle.
- Out of range (req_addr >= DEPTH):
  - A write is dropped with no side effect.
  - A read returns rsp_rdata=0 with rsp_err=1 at normal latency.
  - Upper address bits are never truncated or aliased.
- req_be and req_wdata are ignored on reads; req_write is ignored when the request is not accepted.

Optional Feature:
- Macro: DMEM_PARITY_EN.
- Defined:
  - Each byte stores an extra even-parity bit, computed on write and checked on read.
  - Any mismatch sets rsp_err=1 with the raw data still returned.
  - The clear sequence writes correct parity (0).
- Undefined: no parity storage; rsp_err reflects out-of-range only.

Decomposition:
- Shared package dmem_pkg holds:
  - FSM state enum {CLEAR, READY};
  - constant BYTE_W=8;
  - a function for byte-parity generation.
- One sub-module, dmem_array: a single-port array with byte-write enables and registered read, instantiated once.
- The FSM, range check and latency pipeline stay in dmem_ctrl.

Test Plan:
- Reset, then hold req_valid=1 -> req_ready=0 and clr_busy=1 for exactly 1024 cycles, then req_ready=1; read addr 5 returns 0x00000000 with rsp_err=0.
- Write 0xDEADBEEF to addr 10 with be=4'b1111, then write 0x000000AA with be=4'b0001, then read 10 -> rsp_rdata=0xDEADBEAA exactly READ_LAT cycles after accept.
- Write to addr 1024, then read addr 1024 -> rsp_valid=1, rsp_rdata=0, rsp_err=1; a read of addr 0 is unaffected.
- Reads to addrs 1,2,3 on consecutive cycles with READ_LAT=2 -> three consecutive rsp_valid pulses carrying data in order 1,2,3.
- Assert reset_n=0 at clear count 500, release -> clear restarts at 0 and lasts 1024 more cycles; a read outstanding at reset produces no response.
- With DMEM_PARITY_EN defined, force a flipped stored bit at addr 7 and read 7 -> rsp_err=1 with the corrupted data returned.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types, constants and the byte-parity helper for the dmem_ctrl data memory.
// Parity storage is only built when DMEM_PARITY_EN is defined.
package dmem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int BYTE_W = 8;

  // Even parity: the stored bit makes the total number of ones in byte+bit even.
  function automatic logic byte_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array with byte write enables and a registered read port.
// With DMEM_PARITY_EN defined, each byte carries an even-parity bit checked on read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  localparam int AW    = $clog2(DEPTH),
  localparam int NB    = DATA_W / BYTE_W
) (
  input  logic              clock,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [NB-1:0]     be,
  output logic [DATA_W-1:0] rdata,
  output logic              perr
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Storage is intentionally not reset; the controller's clear sequence initialises it.
  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
        end
      end
    end
    if (re) begin
      rdata_r <= mem[addr];
    end
  end

  assign rdata = rdata_r;

`ifdef DMEM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] rd_par_s;
  logic          perr_r;

  always_comb begin
    rd_par_s = {NB{1'b0}};
    for (int i = 0; i < NB; i++) begin
      rd_par_s[i] = byte_parity(mem[addr][i*BYTE_W +: BYTE_W]);
    end
  end

  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          par_mem[addr][i] <= byte_parity(wdata[i*BYTE_W +: BYTE_W]);
        end
      end
    end
    if (re) begin
      perr_r <= (rd_par_s != par_mem[addr]);
    end
  end

  assign perr = perr_r;
`else
  assign perr = 1'b0;
`endif

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory controller: valid/ready request port, post-reset clear, range check and
// a READ_LAT (1 or 2) response pipeline. Optional byte parity via DMEM_PARITY_EN.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int DEPTH          = 1024,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  input  logic [DATA_W/8-1:0]    req_be,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   clr_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = DATA_W / BYTE_W;
  localparam logic [ADDR_W:0] DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [AW-1:0]   LAST_WORD = AW'(DEPTH - 1);
  localparam state_t          RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  state_t            state_r, state_next;
  logic [AW-1:0]     clr_cnt_r, clr_cnt_next;
  logic              clr_busy_r, clr_busy_next;
  logic              req_ready_r, req_ready_next;
  logic              clr_we_s;

  logic              accept_s, in_range_s;
  logic              arr_we_s, arr_re_s, arr_perr_s;
  logic [AW-1:0]     arr_addr_s;
  logic [NB-1:0]     arr_be_s;
  logic [DATA_W-1:0] arr_wdata_s, arr_rdata_s;

  logic              rd_v1_r, rd_oor1_r;
  logic              rd_v2_r, rd_e2_r;
  logic [DATA_W-1:0] rd_d2_r;
  logic              s1_v_s, s1_e_s, src_v_s, src_e_s;
  logic [DATA_W-1:0] s1_d_s, src_d_s;

  logic              rsp_valid_r, rsp_err_r;
  logic [DATA_W-1:0] rsp_rdata_r;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= RST_STATE;
      clr_cnt_r   <= {AW{1'b0}};
      clr_busy_r  <= 1'b0;
      req_ready_r <= 1'b0;
    end else begin
      state_r     <= state_next;
      clr_cnt_r   <= clr_cnt_next;
      clr_busy_r  <= clr_busy_next;
      req_ready_r <= req_ready_next;
    end
  end

  // The first edge after reset only raises clr_busy; the DEPTH clear writes follow it.
  always_comb begin
    state_next     = state_r;
    clr_cnt_next   = clr_cnt_r;
    clr_busy_next  = 1'b0;
    req_ready_next = 1'b0;
    clr_we_s       = 1'b0;
    case (state_r)
      CLEAR: begin
        clr_busy_next = 1'b1;
        if (clr_busy_r) begin
          clr_we_s = 1'b1;
          if (clr_cnt_r == LAST_WORD) begin
            state_next     = READY;
            clr_cnt_next   = {AW{1'b0}};
            clr_busy_next  = 1'b0;
            req_ready_next = 1'b1;
          end else begin
            clr_cnt_next = clr_cnt_r + AW'(1);
          end
        end else begin
          clr_cnt_next = {AW{1'b0}};
        end
      end
      READY: begin
        req_ready_next = 1'b1;
      end
      default: begin
        state_next = RST_STATE;
      end
    endcase
  end

  assign accept_s   = req_valid & req_ready_r;
  assign in_range_s = ({1'b0, req_addr} < DEPTH_X);

  assign arr_we_s    = clr_we_s | (accept_s & req_write & in_range_s);
  assign arr_re_s    = accept_s & ~req_write & in_range_s;
  assign arr_addr_s  = clr_we_s ? clr_cnt_r : req_addr[AW-1:0];
  assign arr_be_s    = clr_we_s ? {NB{1'b1}} : req_be;
  assign arr_wdata_s = clr_we_s ? {DATA_W{1'b0}} : req_wdata;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clock (clock),
    .we    (arr_we_s),
    .re    (arr_re_s),
    .addr  (arr_addr_s),
    .wdata (arr_wdata_s),
    .be    (arr_be_s),
    .rdata (arr_rdata_s),
    .perr  (arr_perr_s)
  );

  // Stage 1 pairs the array's registered read with the range flag captured at accept.
  assign s1_v_s = rd_v1_r;
  assign s1_e_s = rd_oor1_r | arr_perr_s;
  assign s1_d_s = rd_oor1_r ? {DATA_W{1'b0}} : arr_rdata_s;

  assign src_v_s = (READ_LAT == 2) ? rd_v2_r : s1_v_s;
  assign src_e_s = (READ_LAT == 2) ? rd_e2_r : s1_e_s;
  assign src_d_s = (READ_LAT == 2) ? rd_d2_r : s1_d_s;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_v1_r     <= 1'b0;
      rd_oor1_r   <= 1'b0;
      rd_v2_r     <= 1'b0;
      rd_e2_r     <= 1'b0;
      rd_d2_r     <= {DATA_W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
    end else begin
      rd_v1_r     <= accept_s & ~req_write;
      rd_oor1_r   <= ~in_range_s;
      rd_v2_r     <= s1_v_s;
      rd_e2_r     <= s1_e_s;
      rd_d2_r     <= s1_d_s;
      rsp_valid_r <= src_v_s;
      rsp_err_r   <= src_v_s & src_e_s;
      rsp_rdata_r <= src_v_s ? src_d_s : {DATA_W{1'b0}};
    end
  end

  assign req_ready = req_ready_r;
  assign clr_busy  = clr_busy_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;

endmodule
